// File: rtl/square_mac_seq.sv
`default_nettype none
// ============================================================================
// Module      : square_mac_seq
// Description : Job sequencer for the signed square/multiply-accumulate unit.
//               It accepts a job of cfg_len sample pairs and streams the pairs
//               from a valid/ready source into the MAC, pulsing sload on the
//               first pair. It then drains the MAC pipeline and presents the
//               accumulated result on a valid/ready result port.
//               Optional feature macro: SQMAC_SEQ_TIMEOUT_EN (starvation
//               timeout that ends RUN early and flags res_err).
// Revision    : 1.0 - initial release
// ============================================================================
module square_mac_seq #(
    parameter int W       = 16,
    parameter int PW      = 48,
    parameter int LW      = 16,
    parameter int MAC_LAT = 2,
    parameter int TO_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LW-1:0]        cfg_len,
    input  logic [TO_W-1:0]      cfg_timeout,
    output logic                 busy,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [W-1:0]  s_a,
    input  logic signed [W-1:0]  s_b,
    output logic                 mac_sload,
    output logic signed [W-1:0]  mac_ain,
    output logic signed [W-1:0]  mac_bin,
    input  logic signed [PW-1:0] mac_pout,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic signed [PW-1:0] res_data,
    output logic [LW-1:0]        res_cnt,
    output logic                 res_err
);

    // Drain counter is wide enough to reach MAC_LAT with headroom.
    localparam int              c_DW         = $clog2(MAC_LAT + 1) + 1;
    localparam logic [c_DW-1:0] c_DRAIN_LAST = c_DW'(MAC_LAT);
    localparam logic [c_DW-1:0] c_DRAIN_ONE  = c_DW'(1);
    localparam logic [LW-1:0]   c_LEN_ONE    = LW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [LW-1:0]   r_len;
    logic            r_first;
    logic [c_DW-1:0] r_drain_cnt;
    logic            w_start_ok;
    logic            w_xfer;
    logic            w_last;
    logic            w_drain_end;
    logic            w_to_hit;

    // s_ready is exactly "state is RUN", so the transfer is derived from the
    // state directly rather than from the combinational s_ready output.
    assign w_start_ok  = (r_state == IDLE) && start;
    assign w_xfer      = (r_state == RUN) && s_valid;
    assign w_last      = (res_cnt == (r_len - c_LEN_ONE));
    assign w_drain_end = (r_state == DRAIN) && (r_drain_cnt == c_DRAIN_LAST);

`ifdef SQMAC_SEQ_TIMEOUT_EN
    logic [TO_W-1:0] r_to_cnt;
    logic [TO_W-1:0] r_to_lim;
    logic            r_err;

    // Fires on the idle RUN cycle that completes cfg_timeout consecutive
    // cycles without a transfer; a zero limit disables it.
    assign w_to_hit = (r_state == RUN) && !w_xfer && (r_to_lim != '0) &&
                      (r_to_cnt == (r_to_lim - TO_W'(1)));
    assign res_err  = r_err;

    // Starvation counter: limit latched with the job, cleared by each transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
            r_to_lim <= '0;
            r_err    <= 1'b0;
        end else if (w_start_ok) begin
            r_to_cnt <= '0;
            r_to_lim <= cfg_timeout;
            r_err    <= 1'b0;
        end else if (r_state == RUN) begin
            r_to_cnt <= w_xfer ? '0 : (r_to_cnt + TO_W'(1));
            if (w_to_hit) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^cfg_timeout;
    assign w_to_hit         = 1'b0;
    assign res_err          = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        s_ready     = 1'b0;
        res_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (cfg_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                s_ready = 1'b1;
                if (w_xfer && w_last) begin
                    w_state_nxt = DRAIN;
                end else if (w_to_hit) begin
                    // Nothing reached the MAC, so there is nothing to drain.
                    w_state_nxt = (res_cnt == '0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (w_drain_end) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Job bookkeeping: length, first-pair flag, pair count and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len    <= '0;
            r_first  <= 1'b0;
            res_cnt  <= '0;
            res_data <= '0;
        end else begin
            if (w_start_ok) begin
                r_len    <= cfg_len;
                r_first  <= 1'b1;
                res_cnt  <= '0;
                res_data <= '0;
            end
            if (w_xfer) begin
                r_first <= 1'b0;
                res_cnt <= res_cnt + c_LEN_ONE;
            end
            if (w_drain_end) begin
                res_data <= mac_pout;
            end
        end
    end

    // MAC drive: a transferred pair for one cycle, zeros otherwise so that
    // bubbles and drain cycles add nothing to the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_sload <= 1'b0;
            mac_ain   <= '0;
            mac_bin   <= '0;
        end else begin
            mac_sload <= w_xfer && r_first;
            mac_ain   <= w_xfer ? s_a : '0;
            mac_bin   <= w_xfer ? s_b : '0;
        end
    end

    // Drain counter restarts at zero on every entry into DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drain_cnt <= '0;
        end else if (r_state != DRAIN) begin
            r_drain_cnt <= '0;
        end else begin
            r_drain_cnt <= r_drain_cnt + c_DRAIN_ONE;
        end
    end

endmodule
`default_nettype wire
